bist_sequencer: RTL
===================

Name: bist_sequencer

Overview:
Self-contained BIST controller that sequences the 247-bit pattern LFSR, the scan chain and the pattern counters through init / shift / capture / compare. It compacts scan-out into a MISR and compares the final signature against a golden value. Sits between the top-level test enable and the lfsr247/scan datapath, replacing the one-hot FSM plus external counters with one sequencer.

Parameters:
CHAIN_LEN, 247, scan chain length (shift cycles per pattern); must be >= 1
NUM_TESTS, 511, number of capture cycles (patterns applied); must be >= 1
SIG_W, 16, MISR/signature width; must be >= 2
POLY, 16'h002D, MISR feedback polynomial (bit i set = XOR into bit i)
GOLDEN, 16'h0000, expected final signature

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
bist_en  input  1  level: run BIST while high; low aborts to idle
scan_out  input  1  serial chain output, sampled during SHIFT
lfsr_init  output  1  one-cycle strobe: LFSR to seed state
lfsr_next  output  1  LFSR advance enable
scan_en  output  1  chain shift enable
capture  output  1  one-cycle functional capture strobe
busy  output  1  high in INIT/SHIFT/CAPTURE/COMPARE
done  output  1  high while in DONE
pass  output  1  signature == GOLDEN; valid only while done=1
signature  output  SIG_W  current MISR contents (debug)

Behaviour:
- Reset (async, immediate): state IDLE; shift_cnt, test_cnt, misr, pass_q = 0; all outputs 0.
- Moore outputs decoded from the one-hot state register only, with no combinational path from inputs:
  - lfsr_init = INIT
  - lfsr_next = scan_en = SHIFT
  - capture = CAPTURE
  - done = DONE
  - pass = DONE & pass_q
- States and transitions, evaluated each rising edge. If bist_en=0 in any state, next state is IDLE. Otherwise:
  - IDLE -> INIT.
  - INIT (1 cycle): clear shift_cnt, test_cnt, misr -> SHIFT.
  - SHIFT: shift_cnt++. When shift_cnt == CHAIN_LEN-1: clear shift_cnt; go to CAPTURE if test_cnt < NUM_TESTS, else COMPARE.
  - CAPTURE (1 cycle): test_cnt++ -> SHIFT.
  - COMPARE (1 cycle): pass_q <= (misr == GOLDEN) -> DONE.
  - DONE: hold; all strobes 0; done=1, pass stable until bist_en falls.
- Run length, from INIT entry to DONE entry: 1 + (NUM_TESTS+1)*CHAIN_LEN + NUM_TESTS + 1 cycles.
  - lfsr_next high for exactly (NUM_TESTS+1)*CHAIN_LEN cycles.
  - capture pulses exactly NUM_TESTS times.
- MISR:
  - Updates only in SHIFT with test_cnt != 0. The first load shift is not compacted because chain contents are unknown.
  - Update rule: misr <= (misr << 1) ^ (misr[SIG_W-1] ? POLY : 0) ^ {0.., scan_out}, truncated to SIG_W.
  - The final unload shift (test_cnt == NUM_TESTS) is compacted.
- Counter widths:
  - shift_cnt: $clog2(CHAIN_LEN+1)
  - test_cnt: $clog2(NUM_TESTS+1)
  - No wrap is reachable. Counters reload only in INIT.
- Abort (bist_en low mid-run): IDLE next edge, strobes drop, pass_q cleared. Re-enable restarts from INIT with no residual state.
- Reset mid-operation: same as power-on reset, asynchronous.

Decomposition:
- Shared package bist_pkg holds:
  - one-hot state encoding constants (IDLE, INIT, SHIFT, CAPTURE, COMPARE, DONE)
  - the state vector typedef
  - default MISR polynomial
- One natural sub-module: bist_misr (SIG_W, POLY; ports clk, reset, clear, en, din, sig).

Test Plan:
All scenarios use CHAIN_LEN=4, NUM_TESTS=2, SIG_W=8, POLY=8'h1D.
1. Assert reset at an arbitrary time mid-CAPTURE -> all outputs 0 immediately without a clock edge; state IDLE after release.
2. GOLDEN=8'h00, scan_out=0, bist_en=1 -> lfsr_init 1 cycle; lfsr_next high 12 cycles in three runs of 4; capture 2 single-cycle pulses; done rises 16 cycles after INIT entry; signature=8'h00; pass=1.
3. GOLDEN=8'h00, scan_out=1 -> 8 compacted cycles; signature=8'hFF; done=1, pass=0.
4. GOLDEN=8'hFF, scan_out=1 -> signature=8'hFF, pass=1. Also confirms the first 4 shift cycles are not compacted: compacting them too would give a different value.
5. Drop bist_en during the 2nd SHIFT block -> next edge IDLE, all strobes and busy 0. Re-raise -> INIT again; full 16-cycle sequence repeats with identical strobe counts.
6. Hold bist_en 10 cycles after done -> done, pass, signature stable; no strobes. Drop bist_en -> IDLE, done=0, pass=0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer: one-hot state encoding and the default MISR polynomial.
package bist_pkg;

   localparam int IDLE_BIT    = 0;
   localparam int INIT_BIT    = 1;
   localparam int SHIFT_BIT   = 2;
   localparam int CAPTURE_BIT = 3;
   localparam int COMPARE_BIT = 4;
   localparam int DONE_BIT    = 5;
   localparam int NUM_STATES  = 6;

   typedef enum logic [NUM_STATES-1:0] {
      ST_IDLE    = 6'(1 << IDLE_BIT),
      ST_INIT    = 6'(1 << INIT_BIT),
      ST_SHIFT   = 6'(1 << SHIFT_BIT),
      ST_CAPTURE = 6'(1 << CAPTURE_BIT),
      ST_COMPARE = 6'(1 << COMPARE_BIT),
      ST_DONE    = 6'(1 << DONE_BIT)
   } bist_state_t;

   localparam logic [15:0] MISR_POLY_DEFAULT = 16'h002D;

endpackage

// File: rtl/bist_misr.sv
// Serial-input signature register that compacts the scan-out stream one bit per enabled cycle.
module bist_misr
   import bist_pkg::*;
#(
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY_DEFAULT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic             din,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   // Clear has priority so a fresh run never inherits a stale signature.
   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : '0)
               ^ {{(SIG_W-1){1'b0}}, din};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/bist_sequencer.sv
// BIST sequencer: walks init/shift/capture/compare over the scan chain and checks the MISR signature.
module bist_sequencer
   import bist_pkg::*;
#(
   parameter int               CHAIN_LEN = 247,
   parameter int               NUM_TESTS = 511,
   parameter int               SIG_W     = 16,
   parameter logic [SIG_W-1:0] POLY      = SIG_W'(MISR_POLY_DEFAULT),
   parameter logic [SIG_W-1:0] GOLDEN    = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bist_en,
   input  logic             scan_out,
   output logic             lfsr_init,
   output logic             lfsr_next,
   output logic             scan_en,
   output logic             capture,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);

   localparam int SW = $clog2(CHAIN_LEN + 1);
   localparam int TW = $clog2(NUM_TESTS + 1);
   localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
   localparam logic [TW-1:0] TESTS_MAX  = TW'(NUM_TESTS);

   bist_state_t state_q, state_d;
   logic [SW-1:0] shift_cnt_q, shift_cnt_d;
   logic [TW-1:0] test_cnt_q, test_cnt_d;
   logic          pass_q, pass_d;
   logic          misrClear;
   logic          misrEn;
   logic [SIG_W-1:0] misrSig;

   bist_misr #(
      .SIG_W (SIG_W),
      .POLY  (POLY)
   ) u_misr (
      .clk   (clk),
      .reset (reset),
      .clear (misrClear),
      .en    (misrEn),
      .din   (scan_out),
      .sig   (misrSig)
   );

   // The first pattern load shifts out unknown chain contents, so it is kept out of the MISR.
   always_comb begin
      state_d     = state_q;
      shift_cnt_d = shift_cnt_q;
      test_cnt_d  = test_cnt_q;
      pass_d      = 1'b0;
      misrClear   = 1'b0;
      misrEn      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_INIT;
         end
         ST_INIT: begin
            shift_cnt_d = '0;
            test_cnt_d  = '0;
            misrClear   = 1'b1;
            state_d     = ST_SHIFT;
         end
         ST_SHIFT: begin
            misrEn = (test_cnt_q != '0);
            if (shift_cnt_q == SHIFT_LAST) begin
               shift_cnt_d = '0;
               state_d     = (test_cnt_q < TESTS_MAX) ? ST_CAPTURE : ST_COMPARE;
            end else begin
               shift_cnt_d = shift_cnt_q + SW'(1);
            end
         end
         ST_CAPTURE: begin
            test_cnt_d = test_cnt_q + TW'(1);
            state_d    = ST_SHIFT;
         end
         ST_COMPARE: begin
            pass_d  = (misrSig == GOLDEN);
            state_d = ST_DONE;
         end
         ST_DONE: begin
            pass_d = pass_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (!bist_en) begin
         state_d = ST_IDLE;
         pass_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shift_cnt_q <= '0;
         test_cnt_q  <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_cnt_q <= shift_cnt_d;
         test_cnt_q  <= test_cnt_d;
         pass_q      <= pass_d;
      end
   end

   assign lfsr_init = state_q[INIT_BIT];
   assign lfsr_next = state_q[SHIFT_BIT];
   assign scan_en   = state_q[SHIFT_BIT];
   assign capture   = state_q[CAPTURE_BIT];
   assign busy      = state_q[INIT_BIT] | state_q[SHIFT_BIT] | state_q[CAPTURE_BIT] | state_q[COMPARE_BIT];
   assign done      = state_q[DONE_BIT];
   assign pass      = state_q[DONE_BIT] & pass_q;
   assign signature = misrSig;

endmodule
